lc4_cla_pipe: RTL and testbench

- Parametrised, pipelined carry-lookahead adder/subtractor for wider datapaths.
- Next generation of the 16-bit combinational CLA: generalised in width and segment size; adds subtract mode, carry-in chaining and overflow/zero flags.
- The operand is split into NSEG = WIDTH/SEG segments. Each pipeline stage resolves one segment with internal 4-bit lookahead groups and a second lookahead level, then passes the carry to the next stage.
- Valid/ready handshake at both ends; sits between the operand-fetch register and the ALU result mux on long-word paths.

---
 rtl/lc4_cla_pipe.sv | 165 ++++++++++++++++
 tb/tb_lc4_cla_pipe.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/lc4_cla_pipe.sv
// lc4_cla_pipe: pipelined carry-lookahead adder/subtractor.
// The operand is cut into NSEG segments of SEG bits. Each stage resolves one
// segment using 4-bit lookahead groups plus a second lookahead level across
// the groups, then hands its carry to the next stage. Operands are skewed
// through the pipe so that stage k still holds the raw bits it needs.
// A single global advance signal stalls every stage at once.
module lc4_cla_pipe #(
   parameter int WIDTH = 16,
   parameter int SEG   = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   input  logic             in_sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             out_ovf,
   output logic             out_zero
);

   localparam int NSEG = WIDTH / SEG;
   localparam int NGRP = SEG / 4;

   // Reject geometries the segment/group slicing cannot represent.
   if ((SEG < 4) || ((SEG % 4) != 0) || ((WIDTH % SEG) != 0)) begin : g_bad_params
      $error("lc4_cla_pipe: WIDTH must be a multiple of SEG and SEG a multiple of 4");
   end

   // Carries into bits 1..3 of a 4-bit group, fully expanded (no ripple).
   function automatic logic [2:0] la4(input logic [2:0] g, input logic [2:0] p, input logic c0);
      logic [2:0] c;
      c[0] = g[0] | (p[0] & c0);
      c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
      c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
      return c;
   endfunction

   // One segment: group generate/propagate, lookahead across groups from the
   // segment carry-in, then in-group lookahead. Returns {carry_out, sum}.
   function automatic logic [SEG:0] seg_add(input logic [SEG-1:0] a, input logic [SEG-1:0] b,
                                            input logic cin);
      logic [SEG-1:0]  g;
      logic [SEG-1:0]  p;
      logic [SEG-1:0]  c;
      logic [NGRP-1:0] gg;
      logic [NGRP-1:0] gp;
      logic [NGRP:0]   gc;
      logic [2:0]      bc;
      logic            term;
      logic            acc;
      g = a & b;
      p = a | b;
      for (int j = 0; j < NGRP; j++) begin
         gg[j] = g[4*j+3] | (p[4*j+3] & g[4*j+2]) | (p[4*j+3] & p[4*j+2] & g[4*j+1])
               | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
         gp[j] = &p[4*j +: 4];
      end
      gc[0] = cin;
      for (int j = 0; j < NGRP; j++) begin
         acc = 1'b0;
         for (int i = 0; i <= j; i++) begin
            term = gg[i];
            for (int m = i + 1; m <= j; m++) term = term & gp[m];
            acc = acc | term;
         end
         term = cin;
         for (int m = 0; m <= j; m++) term = term & gp[m];
         gc[j+1] = acc | term;
      end
      c = '0;
      for (int j = 0; j < NGRP; j++) begin
         bc         = la4(g[4*j +: 3], p[4*j +: 3], gc[j]);
         c[4*j]     = gc[j];
         c[4*j+1]   = bc[0];
         c[4*j+2]   = bc[1];
         c[4*j+3]   = bc[2];
      end
      return {gc[NGRP], a ^ b ^ c};
   endfunction

   logic [WIDTH-1:0] st_a     [NSEG];
   logic [WIDTH-1:0] st_b     [NSEG];
   logic [WIDTH-1:0] st_sum   [NSEG];
   logic [WIDTH-1:0] next_sum [NSEG];
   logic [SEG:0]     seg_res  [NSEG];
   logic [NSEG-1:0]  st_c;
   logic [NSEG-1:0]  st_v;
   logic [NSEG-1:0]  st_amsb;
   logic [NSEG-1:0]  st_bmsb;
   logic             advance;

   assign advance  = !out_valid || out_ready;
   assign in_ready = advance;
   assign out_zero = (out_sum == '0);

   // Resolve the segment owned by each stage and splice it into the partial sum.
   always_comb begin
      for (int k = 0; k < NSEG; k++) begin
         seg_res[k]                = seg_add(st_a[k][k*SEG +: SEG], st_b[k][k*SEG +: SEG], st_c[k]);
         next_sum[k]               = st_sum[k];
         next_sum[k][k*SEG +: SEG] = seg_res[k][SEG-1:0];
      end
   end

   // Pipeline stages: stage 0 captures accepted operands, later stages shift on advance.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         st_c    <= '0;
         st_v    <= '0;
         st_amsb <= '0;
         st_bmsb <= '0;
         for (int k = 0; k < NSEG; k++) begin
            st_a[k]   <= '0;
            st_b[k]   <= '0;
            st_sum[k] <= '0;
         end
      end else if (advance) begin
         st_v[0] <= in_valid;
         if (in_valid) begin
            st_a[0]    <= in_a;
            st_b[0]    <= in_sub ? ~in_b : in_b;
            st_c[0]    <= in_cin;
            st_sum[0]  <= '0;
            st_amsb[0] <= in_a[WIDTH-1];
            st_bmsb[0] <= in_sub ? ~in_b[WIDTH-1] : in_b[WIDTH-1];
         end
         for (int k = 1; k < NSEG; k++) begin
            st_v[k] <= st_v[k-1];
            if (st_v[k-1]) begin
               st_a[k]    <= st_a[k-1];
               st_b[k]    <= st_b[k-1];
               st_c[k]    <= seg_res[k-1][SEG];
               st_sum[k]  <= next_sum[k-1];
               st_amsb[k] <= st_amsb[k-1];
               st_bmsb[k] <= st_bmsb[k-1];
            end
         end
      end
   end

   // Output register: only valid beats update the result, bubbles leave it untouched.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid <= 1'b0;
         out_sum   <= '0;
         out_cout  <= 1'b0;
         out_ovf   <= 1'b0;
      end else if (advance) begin
         out_valid <= st_v[NSEG-1];
         if (st_v[NSEG-1]) begin
            out_sum  <= next_sum[NSEG-1];
            out_cout <= seg_res[NSEG-1][SEG];
            out_ovf  <= (st_amsb[NSEG-1] == st_bmsb[NSEG-1])
                     && (next_sum[NSEG-1][WIDTH-1] != st_amsb[NSEG-1]);
         end
      end
   end

endmodule

// File: tb/tb_lc4_cla_pipe.sv
// tb_lc4_cla_pipe: directed checks for a 16-bit/4-bit-segment instance and a
// 32-bit/8-bit-segment instance sharing one clock and reset.
module tb_lc4_cla_pipe;

   logic        clk = 1'b0;
   logic        rst = 1'b0;

   logic        s_in_valid = 1'b0;
   logic        s_in_ready;
   logic [15:0] s_in_a = '0;
   logic [15:0] s_in_b = '0;
   logic        s_in_cin = 1'b0;
   logic        s_in_sub = 1'b0;
   logic        s_out_valid;
   logic        s_out_ready = 1'b1;
   logic [15:0] s_out_sum;
   logic        s_out_cout;
   logic        s_out_ovf;
   logic        s_out_zero;

   logic        w_in_valid = 1'b0;
   logic        w_in_ready;
   logic [31:0] w_in_a = '0;
   logic [31:0] w_in_b = '0;
   logic        w_in_cin = 1'b0;
   logic        w_in_sub = 1'b0;
   logic        w_out_valid;
   logic        w_out_ready = 1'b1;
   logic [31:0] w_out_sum;
   logic        w_out_cout;
   logic        w_out_ovf;
   logic        w_out_zero;

   int checks = 0;
   int errors = 0;

   lc4_cla_pipe #(.WIDTH(16), .SEG(4)) dut16 (
      .clk(clk), .rst(rst),
      .in_valid(s_in_valid), .in_ready(s_in_ready),
      .in_a(s_in_a), .in_b(s_in_b), .in_cin(s_in_cin), .in_sub(s_in_sub),
      .out_valid(s_out_valid), .out_ready(s_out_ready),
      .out_sum(s_out_sum), .out_cout(s_out_cout), .out_ovf(s_out_ovf), .out_zero(s_out_zero)
   );

   lc4_cla_pipe #(.WIDTH(32), .SEG(8)) dut32 (
      .clk(clk), .rst(rst),
      .in_valid(w_in_valid), .in_ready(w_in_ready),
      .in_a(w_in_a), .in_b(w_in_b), .in_cin(w_in_cin), .in_sub(w_in_sub),
      .out_valid(w_out_valid), .out_ready(w_out_ready),
      .out_sum(w_out_sum), .out_cout(w_out_cout), .out_ovf(w_out_ovf), .out_zero(w_out_zero)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // One beat into the 16-bit pipe; result must appear exactly 4 cycles after accept.
   task automatic applyStimulus16(input string tag, input logic [15:0] a, input logic [15:0] b,
                                  input logic cin, input logic sub, input logic [15:0] esum,
                                  input logic ecout, input logic eovf, input logic ezero);
      int early;
      s_in_a = a; s_in_b = b; s_in_cin = cin; s_in_sub = sub; s_in_valid = 1'b1;
      #1;
      checkOutput({tag, ".in_ready"}, 64'(s_in_ready), 64'(1));
      @(posedge clk); #1;
      s_in_valid = 1'b0;
      early = 0;
      for (int i = 0; i < 4; i++) begin
         if (s_out_valid) early++;
         @(posedge clk); #1;
      end
      checkOutput({tag, ".early"}, 64'(early), 64'(0));
      checkOutput({tag, ".valid"}, 64'(s_out_valid), 64'(1));
      checkOutput({tag, ".sum"}, 64'(s_out_sum), 64'(esum));
      checkOutput({tag, ".cout"}, 64'(s_out_cout), 64'(ecout));
      checkOutput({tag, ".ovf"}, 64'(s_out_ovf), 64'(eovf));
      checkOutput({tag, ".zero"}, 64'(s_out_zero), 64'(ezero));
   endtask

   // One beat into the 32-bit pipe (also 4 segments, so 4 cycles of latency).
   task automatic applyStimulus32(input string tag, input logic [31:0] a, input logic [31:0] b,
                                  input logic cin, input logic sub, input logic [31:0] esum,
                                  input logic ecout, input logic eovf, input logic ezero);
      int early;
      w_in_a = a; w_in_b = b; w_in_cin = cin; w_in_sub = sub; w_in_valid = 1'b1;
      @(posedge clk); #1;
      w_in_valid = 1'b0;
      early = 0;
      for (int i = 0; i < 4; i++) begin
         if (w_out_valid) early++;
         @(posedge clk); #1;
      end
      checkOutput({tag, ".early"}, 64'(early), 64'(0));
      checkOutput({tag, ".valid"}, 64'(w_out_valid), 64'(1));
      checkOutput({tag, ".sum"}, 64'(w_out_sum), 64'(esum));
      checkOutput({tag, ".cout"}, 64'(w_out_cout), 64'(ecout));
      checkOutput({tag, ".ovf"}, 64'(w_out_ovf), 64'(eovf));
      checkOutput({tag, ".zero"}, 64'(w_out_zero), 64'(ezero));
   endtask

   // Directed sequence: reset, arithmetic corners, backpressure, mid-flight reset, wide sweep.
   initial begin
      int sent, recv, stall, cnt;
      logic fire_in, fire_out, held_valid;
      logic [15:0] held_sum;
      logic [31:0] ra, rb, rbeff, rsum;
      logic rcin, rsub, rcout, rovf;
      longint rs;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst.valid", 64'(s_out_valid), 64'(0));
      checkOutput("rst.sum", 64'(s_out_sum), 64'(0));
      checkOutput("rst.cout", 64'(s_out_cout), 64'(0));
      checkOutput("rst.ovf", 64'(s_out_ovf), 64'(0));
      checkOutput("rst.zero", 64'(s_out_zero), 64'(1));
      checkOutput("rst.wvalid", 64'(w_out_valid), 64'(0));
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      checkOutput("rst.in_ready", 64'(s_in_ready), 64'(1));

      // Arithmetic corners on the 16-bit pipe
      applyStimulus16("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
      applyStimulus16("sub_borrow", 16'h0000, 16'h0001, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0);
      applyStimulus16("sub_equal", 16'h1234, 16'h1234, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
      applyStimulus16("carry_chain", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
      applyStimulus16("neg_ovf", 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1);
      applyStimulus16("sub_ovf", 16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
      applyStimulus16("mixed_carry", 16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0);

      // Backpressure: 6 back-to-back beats, downstream stalls on cycles 5..8
      @(posedge clk); #1;
      checkOutput("bp.idle", 64'(s_out_valid), 64'(0));
      sent = 0; recv = 0; stall = 0; held_valid = 1'b0; held_sum = '0;
      for (int cyc = 0; cyc < 40 && recv < 6; cyc++) begin
         s_out_ready = !(cyc >= 5 && cyc <= 8);
         s_in_valid  = (sent < 6);
         s_in_a      = 16'(sent + 1);
         s_in_b      = 16'((sent + 1) * 16'h1000);
         s_in_cin    = 1'b0;
         s_in_sub    = 1'b0;
         #1;
         if (held_valid) begin
            checkOutput($sformatf("bp.hold_sum%0d", cyc), 64'(s_out_sum), 64'(held_sum));
            checkOutput($sformatf("bp.hold_valid%0d", cyc), 64'(s_out_valid), 64'(1));
         end
         if (s_out_valid && !s_out_ready) begin
            stall++;
            checkOutput($sformatf("bp.in_ready%0d", cyc), 64'(s_in_ready), 64'(0));
         end
         held_valid = s_out_valid && !s_out_ready;
         held_sum   = s_out_sum;
         fire_in    = s_in_valid && s_in_ready;
         fire_out   = s_out_valid && s_out_ready;
         if (fire_out) begin
            checkOutput($sformatf("bp.sum%0d", recv), 64'(s_out_sum), 64'(16'((recv + 1) * 16'h1001)));
            checkOutput($sformatf("bp.cout%0d", recv), 64'(s_out_cout), 64'(0));
            recv++;
         end
         @(posedge clk); #1;
         if (fire_in) sent++;
      end
      s_in_valid  = 1'b0;
      s_out_ready = 1'b1;
      checkOutput("bp.received", 64'(recv), 64'(6));
      checkOutput("bp.sent", 64'(sent), 64'(6));
      checkOutput("bp.stall_cycles", 64'(stall), 64'(4));
      cnt = 0;
      for (int i = 0; i < 6; i++) begin
         if (s_out_valid) cnt++;
         @(posedge clk); #1;
      end
      checkOutput("bp.no_duplicate", 64'(cnt), 64'(0));

      // Reset with beats in flight and one sitting at the output
      for (int i = 0; i < 5; i++) begin
         s_in_valid = 1'b1;
         s_in_a = 16'(16'h0011 * (i + 1));
         s_in_b = 16'h0100;
         @(posedge clk); #1;
      end
      s_in_valid = 1'b0;
      checkOutput("mid.valid_before", 64'(s_out_valid), 64'(1));
      rst = 1'b0;
      #1;
      checkOutput("mid.valid_async", 64'(s_out_valid), 64'(0));
      checkOutput("mid.sum_async", 64'(s_out_sum), 64'(0));
      checkOutput("mid.zero_async", 64'(s_out_zero), 64'(1));
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      cnt = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (s_out_valid) cnt++;
      end
      checkOutput("mid.no_stale", 64'(cnt), 64'(0));
      applyStimulus16("mid.fresh", 16'h0002, 16'h0003, 1'b0, 1'b0, 16'h0005, 1'b0, 1'b0, 1'b0);

      // Wide instance: full carry chain and a random add/sub sweep
      applyStimulus32("w.carry", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
      applyStimulus32("w.sub", 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 16; i++) begin
         ra    = $urandom;
         rb    = $urandom;
         rcin  = 1'($urandom_range(0, 1));
         rsub  = 1'($urandom_range(0, 1));
         rbeff = rsub ? ~rb : rb;
         {rcout, rsum} = {1'b0, ra} + {1'b0, rbeff} + 33'(rcin);
         rs    = longint'($signed(ra)) + longint'($signed(rbeff)) + longint'(rcin);
         rovf  = (rs > 64'sd2147483647) || (rs < -64'sd2147483648);
         applyStimulus32($sformatf("w.rand%0d", i), ra, rb, rcin, rsub, rsum, rcout, rovf, (rsum == 32'h0));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
